memload_stream_engine: RTL and testbench



---
 rtl/memload_stream_engine.sv | 147 ++++++++++++++
 tb/tb_memload_stream_engine.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memload_stream_engine.sv
// memload_stream_engine: streams a word-address range into a memory write port,
// either packing narrow inbound beats into full words or filling with a pattern.
module memload_stream_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_end,
  input  logic                  cmd_mode,
  input  logic [DATA_WIDTH-1:0] cmd_fill,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  abort,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int unsigned BEATS  = DATA_WIDTH / IN_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FILL   = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic [DATA_WIDTH-1:0] pack;
  logic [DATA_WIDTH-1:0] pack_nxt;
  logic [BEAT_W-1:0]     beat;
  logic                  wr_hs;
  logic                  beat_hs;
  logic                  last_beat;
  logic                  finish;

  assign wr_hs     = mem_we & mem_ready;
  assign beat_hs   = in_valid & in_ready;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  // Command ends on abort or on the handshake of the last address.
  assign finish    = (state != IDLE) && (abort || (wr_hs && (mem_addr == end_addr)));

  // Little-endian placement of the current beat into the pack buffer.
  always_comb begin
    pack_nxt = pack;
    for (int k = 0; k < int'(BEATS); k++) begin
      if (beat == BEAT_W'(k)) begin
        pack_nxt[k*IN_WIDTH +: IN_WIDTH] = in_data;
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      in_ready      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
      end_addr      <= '0;
      pack          <= '0;
      beat          <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            words_written <= '0;
            if (cmd_start > cmd_end) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              mem_addr  <= cmd_start;
              end_addr  <= cmd_end;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              pack      <= '0;
              beat      <= '0;
              if (cmd_mode) begin
                state     <= FILL;
                mem_we    <= 1'b1;
                mem_wdata <= cmd_fill;
              end else begin
                state    <= STREAM;
                in_ready <= 1'b1;
              end
            end
          end
        end
        STREAM, FILL: begin
          // A handshake counts even when abort lands in the same cycle.
          if (wr_hs) begin
            words_written <= words_written + CNT_W'(1);
          end
          if (finish) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b1;
            pack      <= '0;
            beat      <= '0;
          end else if (wr_hs) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            if (state == STREAM) begin
              mem_we   <= 1'b0;
              in_ready <= 1'b1;
            end
          end else if ((state == STREAM) && beat_hs) begin
            pack <= pack_nxt;
            if (last_beat) begin
              mem_we    <= 1'b1;
              mem_wdata <= pack_nxt;
              in_ready  <= 1'b0;
              beat      <= '0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memload_stream_engine.sv
// Scoreboard bench for memload_stream_engine: directed commands push expected
// writes/completions; negedge monitors pop and compare.
module tb_memload_stream_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_start = '0;
  logic [15:0] cmd_end = '0;
  logic        cmd_mode = 1'b0;
  logic [31:0] cmd_fill = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        abort = 1'b0;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [16:0] words_written;

  // Narrow-address instance for the full-range fill
  logic        cmd_valid4 = 1'b0;
  logic        cmd_ready4;
  logic [3:0]  cmd_start4 = '0;
  logic [3:0]  cmd_end4 = '0;
  logic        in_ready4;
  logic        mem_we4;
  logic        mem_ready4 = 1'b1;
  logic [3:0]  mem_addr4;
  logic [31:0] mem_wdata4;
  logic        busy4;
  logic        done4;
  logic        err4;
  logic [4:0]  words_written4;
  logic        in_valid4 = 1'b0;
  logic [7:0]  in_data4 = '0;
  logic        abort4 = 1'b0;

  int checks = 0;
  int errors = 0;
  int w4_cnt = 0;
  int done4_seen = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    logic        e;
    logic [16:0] ww;
  } dn_t;

  wr_t exp_wr[$];
  dn_t exp_dn[$];

  memload_stream_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_end(cmd_end), .cmd_mode(cmd_mode), .cmd_fill(cmd_fill),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .abort(abort),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .words_written(words_written)
  );

  memload_stream_engine #(.DATA_WIDTH(32), .IN_WIDTH(8), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_start(cmd_start4),
    .cmd_end(cmd_end4), .cmd_mode(1'b1), .cmd_fill(32'h5A5A_5A5A),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .abort(abort4),
    .mem_we(mem_we4), .mem_ready(mem_ready4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .busy(busy4), .done(done4), .err(err4), .words_written(words_written4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write / completion monitor for the 16-bit instance
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required none", mem_addr, mem_wdata);
      end else begin
        chk("wr_addr", 64'(mem_addr), 64'(exp_wr[0].addr));
        chk("wr_data", 64'(mem_wdata), 64'(exp_wr[0].data));
        if (mem_ready) void'(exp_wr.pop_front());
      end
    end
    if (rst_n && done) begin
      if (exp_dn.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 err=%0b required none", err);
      end else begin
        chk("done_err", 64'(err), 64'(exp_dn[0].e));
        chk("done_words", 64'(words_written), 64'(exp_dn[0].ww));
        chk("done_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        void'(exp_dn.pop_front());
      end
    end
    if (rst_n && err && !done) begin
      checks++;
      errors++;
      $display("FAIL err_without_done: got err=1 done=0 required err=0");
    end
  end

  // Monitor for the 4-bit instance: addresses must run 0..15 in order
  always @(negedge clk) begin
    if (rst_n && mem_we4 && mem_ready4) begin
      chk("fill4_addr", 64'(mem_addr4), 64'(w4_cnt));
      chk("fill4_data", 64'(mem_wdata4), 64'h5A5A_5A5A);
      w4_cnt++;
    end
    if (rst_n && done4) begin
      chk("fill4_words", 64'(words_written4), 64'd16);
      chk("fill4_count", 64'(w4_cnt), 64'd16);
      done4_seen++;
    end
  end

  // All tasks start and end at posedge+1
  task automatic send_cmd(input logic [15:0] s, input logic [15:0] e,
                          input logic m, input logic [31:0] f);
    chk("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_start = s;
    cmd_end   = e;
    cmd_mode  = m;
    cmd_fill  = f;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 required 1 for beat 0x%0h", d);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (exp_wr.size() == 0 && exp_dn.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d writes %0d dones pending required 0", exp_wr.size(), exp_dn.size());
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_words"}, 64'(words_written), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // STREAM 0x10..0x12, beats 0x00..0x0B
    exp_wr.push_back('{16'h0010, 32'h0302_0100});
    exp_wr.push_back('{16'h0011, 32'h0706_0504});
    exp_wr.push_back('{16'h0012, 32'h0B0A_0908});
    exp_dn.push_back('{1'b0, 17'd3});
    send_cmd(16'h0010, 16'h0012, 1'b0, 32'h0);
    chk("stream_busy", 64'(busy), 64'd1);
    chk("stream_addr", 64'(mem_addr), 64'h10);
    for (int i = 0; i < 12; i++) send_beat(8'(i));
    wait_idle();

    // FILL 0x100..0x103 with toggling mem_ready
    for (int i = 0; i < 4; i++) exp_wr.push_back('{16'(16'h0100 + i), 32'hDEAD_BEEF});
    exp_dn.push_back('{1'b0, 17'd4});
    send_cmd(16'h0100, 16'h0103, 1'b1, 32'hDEAD_BEEF);
    chk("fill_busy", 64'(busy), 64'd1);
    chk("fill_we", 64'(mem_we), 64'd1);
    chk("fill_addr", 64'(mem_addr), 64'h100);
    for (int n = 0; n < 40; n++) begin
      if (exp_dn.size() == 0) break;
      mem_ready = ~mem_ready;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    wait_idle();

    // Rejected command: start > end
    exp_dn.push_back('{1'b1, 17'd0});
    send_cmd(16'd5, 16'd4, 1'b0, 32'h0);
    chk("reject_busy", 64'(busy), 64'd0);
    chk("reject_we", 64'(mem_we), 64'd0);
    wait_idle();

    // STREAM 0..7 aborted after two words and two beats
    exp_wr.push_back('{16'h0000, 32'h2322_2120});
    exp_wr.push_back('{16'h0001, 32'h2726_2524});
    send_cmd(16'h0000, 16'h0007, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) send_beat(8'(8'h20 + i));
    exp_dn.push_back('{1'b0, 17'd2});
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_done", 64'(done), 64'd1);
    // Next command issued in the done cycle
    exp_wr.push_back('{16'h0030, 32'hA3A2_A1A0});
    exp_dn.push_back('{1'b0, 17'd1});
    send_cmd(16'h0030, 16'h0030, 1'b0, 32'h0);
    chk("post_abort_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) send_beat(8'(8'hA0 + i));
    wait_idle();

    // Full-range FILL on the 4-bit address instance
    cmd_start4 = 4'd0;
    cmd_end4   = 4'd15;
    cmd_valid4 = 1'b1;
    @(posedge clk);
    #1 cmd_valid4 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done4_seen != 0) break;
      @(posedge clk);
      #1;
    end
    chk("fill4_done_seen", 64'(done4_seen), 64'd1);
    chk("fill4_we_after", 64'(mem_we4), 64'd0);
    chk("fill4_addr_nowrap", 64'(mem_addr4), 64'd15);

    // Asynchronous reset in the middle of a STREAM word
    send_cmd(16'h0040, 16'h0041, 1'b0, 32'h0);
    send_beat(8'hFF);
    send_beat(8'hEE);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rel_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    exp_wr.push_back('{16'h0050, 32'h4433_2211});
    exp_dn.push_back('{1'b0, 17'd1});
    send_cmd(16'h0050, 16'h0050, 1'b0, 32'h0);
    send_beat(8'h11);
    send_beat(8'h22);
    send_beat(8'h33);
    send_beat(8'h44);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("final_wr_queue", 64'(exp_wr.size()), 64'd0);
    chk("final_dn_queue", 64'(exp_dn.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
